// File: rtl/mem_access_ctrl_if.sv
// Pipeline request/response channel plus data-bus channel of the load/store controller.
// The controller uses the slave view; the pipeline/memory side uses the master view.
interface mem_access_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [3:0]            req_op;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic [1:0]            rsp_exc;
    logic                  bus_req;
    logic                  bus_we;
    logic [ADDR_W-1:0]     bus_addr;
    logic [DATA_W/8-1:0]   bus_byteen;
    logic [DATA_W-1:0]     bus_wdata;
    logic                  bus_gnt;
    logic                  bus_rvalid;
    logic [DATA_W-1:0]     bus_rdata;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, rsp_ready,
               bus_gnt, bus_rvalid, bus_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_exc,
               bus_req, bus_we, bus_addr, bus_byteen, bus_wdata
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, rsp_ready,
               bus_gnt, bus_rvalid, bus_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_exc,
               bus_req, bus_we, bus_addr, bus_byteen, bus_wdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store controller: lane-aligns stores, extends loads,
// flags misaligned/illegal-size/timeout accesses, stalls on a variable-latency bus.
module mem_access_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    mem_access_ctrl_if.slave  io
);
    localparam int NB = DATA_W / 8;
    localparam int LB = $clog2(NB);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_R, RESP} state_t;
    state_t state, state_n;

    logic              r_we, r_uns;
    logic [1:0]        r_size, r_exc;
    logic [LB-1:0]     r_lane;
    logic [ADDR_W-1:0] r_addr;
    logic [NB-1:0]     r_be;
    logic [DATA_W-1:0] r_wd, r_rdata;
    logic [TW-1:0]     timer;

    // Accept-time decode, straight from the request fields
    logic [1:0]        a_size, a_exc;
    logic [LB-1:0]     a_lane;
    logic [3:0]        a_bytes;
    logic [NB-1:0]     a_be;
    logic [DATA_W-1:0] a_wd;

    always_comb begin
        a_size  = io.req_op[2:1];
        a_lane  = io.req_addr[LB-1:0];
        a_bytes = 4'd1 << a_size;
        a_exc   = 2'd0;
        if (DATA_W == 32 && a_size == 2'd3)
            a_exc = 2'd2;
        else if ((a_lane & LB'(a_bytes - 4'd1)) != '0)
            a_exc = 2'd1;
        a_be = ~({NB{1'b1}} << a_bytes);
        a_be = a_be << a_lane;
        a_wd = (io.req_wdata & ~({DATA_W{1'b1}} << {a_bytes, 3'b000})) << {a_lane, 3'b000};
    end

    // Load extension: the top bit of the size mask selects the sign bit
    logic [DATA_W-1:0] l_sh, l_mask, l_top, l_ext;
    logic [6:0]        l_nbits;

    always_comb begin
        l_sh    = io.bus_rdata >> {r_lane, 3'b000};
        l_nbits = 7'd8 << r_size;
        l_mask  = ~({DATA_W{1'b1}} << l_nbits);
        l_top   = l_mask & ~(l_mask >> 1);
        l_ext   = (l_sh & l_mask) | ((!r_uns && |(l_sh & l_top)) ? ~l_mask : '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (io.req_valid) state_n = (a_exc != 2'd0) ? RESP : ISSUE;
            ISSUE:   if (io.bus_gnt) state_n = r_we ? RESP : WAIT_R;
            WAIT_R:  if (io.bus_rvalid || timer == TW'(TIMEOUT)) state_n = RESP;
            RESP:    if (io.rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_size  <= '0;
            r_exc   <= '0;
            r_lane  <= '0;
            r_addr  <= '0;
            r_be    <= '0;
            r_wd    <= '0;
            r_rdata <= '0;
            timer   <= '0;
        end else begin
            case (state)
                IDLE: if (io.req_valid) begin
                    r_we    <= io.req_op[3];
                    r_uns   <= io.req_op[0];
                    r_size  <= a_size;
                    r_lane  <= a_lane;
                    r_addr  <= {io.req_addr[ADDR_W-1:LB], {LB{1'b0}}};
                    r_be    <= io.req_op[3] ? a_be : '0;
                    r_wd    <= io.req_op[3] ? a_wd : '0;
                    r_exc   <= a_exc;
                    r_rdata <= '0;
                end
                ISSUE: timer <= '0;
                WAIT_R: begin
                    timer <= timer + 1'b1;
                    if (io.bus_rvalid)               r_rdata <= l_ext;
                    else if (timer == TW'(TIMEOUT))  r_exc   <= 2'd3;
                end
                default: ;
            endcase
        end
    end

    // All outputs decode from registered state only
    logic issue, resp;
    assign issue         = (state == ISSUE);
    assign resp          = (state == RESP);
    assign io.req_ready  = (state == IDLE);
    assign io.bus_req    = issue;
    assign io.bus_we     = issue & r_we;
    assign io.bus_addr   = issue ? r_addr : '0;
    assign io.bus_byteen = issue ? r_be : '0;
    assign io.bus_wdata  = issue ? r_wd : '0;
    assign io.rsp_valid  = resp;
    assign io.rsp_rdata  = resp ? r_rdata : '0;
    assign io.rsp_exc    = resp ? r_exc : '0;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a 32-bit instance and a 64-bit instance with TIMEOUT=4.
module tb_mem_access_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   nerr = 0;
    int   nchk = 0;

    always #5 clk = ~clk;

    mem_access_ctrl_if #(.DATA_W(32), .ADDR_W(32)) if32 ();
    mem_access_ctrl_if #(.DATA_W(64), .ADDR_W(32)) if64 ();

    mem_access_ctrl #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(255)) u32 (
        .clk(clk), .reset_n(rst_n), .io(if32.slave));
    mem_access_ctrl #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(4)) u64 (
        .clk(clk), .reset_n(rst_n), .io(if64.slave));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request at a negedge; it is accepted at the next posedge.
    task automatic req32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] w);
        if32.req_valid = 1'b1; if32.req_op = op; if32.req_addr = a; if32.req_wdata = w;
        @(negedge clk);
        if32.req_valid = 1'b0; if32.req_op = 4'hF; if32.req_addr = '1; if32.req_wdata = '1;
    endtask

    task automatic req64(input logic [3:0] op, input logic [31:0] a, input logic [63:0] w);
        if64.req_valid = 1'b1; if64.req_op = op; if64.req_addr = a; if64.req_wdata = w;
        @(negedge clk);
        if64.req_valid = 1'b0; if64.req_op = 4'hF; if64.req_addr = '1; if64.req_wdata = '1;
    endtask

    // Load with grant in cycle 1 and rvalid in cycle 2; returns in the first RESP cycle.
    task automatic load32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rd);
        req32(op, a, 32'h0);
        if32.bus_gnt = 1'b1;
        @(negedge clk);
        if32.bus_gnt = 1'b0; if32.bus_rvalid = 1'b1; if32.bus_rdata = rd;
        @(negedge clk);
        if32.bus_rvalid = 1'b0; if32.bus_rdata = '0;
    endtask

    task automatic load64(input logic [3:0] op, input logic [31:0] a, input logic [63:0] rd);
        req64(op, a, 64'h0);
        if64.bus_gnt = 1'b1;
        @(negedge clk);
        if64.bus_gnt = 1'b0; if64.bus_rvalid = 1'b1; if64.bus_rdata = rd;
        @(negedge clk);
        if64.bus_rvalid = 1'b0; if64.bus_rdata = '0;
    endtask

    task automatic rsp32(input string tag);
        if32.rsp_ready = 1'b1;
        @(negedge clk);
        if32.rsp_ready = 1'b0;
        chk({tag, "_idle"}, {if32.req_ready, if32.rsp_valid}, 2'b10);
    endtask

    task automatic rsp64(input string tag);
        if64.rsp_ready = 1'b1;
        @(negedge clk);
        if64.rsp_ready = 1'b0;
        chk({tag, "_idle"}, {if64.req_ready, if64.rsp_valid}, 2'b10);
    endtask

    initial begin
        rst_n = 1'b0;
        if32.req_valid = 0; if32.req_op = 0; if32.req_addr = 0; if32.req_wdata = 0;
        if32.rsp_ready = 0; if32.bus_gnt = 0; if32.bus_rvalid = 0; if32.bus_rdata = 0;
        if64.req_valid = 0; if64.req_op = 0; if64.req_addr = 0; if64.req_wdata = 0;
        if64.rsp_ready = 0; if64.bus_gnt = 0; if64.bus_rvalid = 0; if64.bus_rdata = 0;
        #1;
        chk("rst_ready32", if32.req_ready, 1'b1);
        chk("rst_outs32", {if32.bus_req, if32.bus_we, if32.bus_byteen, if32.rsp_valid, if32.rsp_exc}, 0);
        chk("rst_data32", {if32.bus_addr, if32.rsp_rdata}, 0);
        chk("rst_ready64", {if64.req_ready, if64.bus_req, if64.rsp_valid}, 3'b100);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // SB at lane 3, immediate grant
        req32(4'b1000, 32'h1003, 32'h0000_00A5);
        chk("sb_req", {if32.bus_req, if32.bus_we, if32.rsp_valid}, 3'b110);
        chk("sb_be", if32.bus_byteen, 4'b1000);
        chk("sb_wdata", if32.bus_wdata, 32'hA500_0000);
        chk("sb_addr", if32.bus_addr, 32'h0000_1000);
        if32.bus_gnt = 1'b1;
        @(negedge clk);
        if32.bus_gnt = 1'b0;
        chk("sb_rsp", {if32.rsp_valid, if32.rsp_exc, if32.bus_req}, 4'b1000);
        chk("sb_rdata", if32.rsp_rdata, 0);
        rsp32("sb");

        // LB signed, lane 1, plus RESP hold with stray rvalid
        req32(4'b0000, 32'h2001, 32'h0);
        chk("lb_bus", {if32.bus_req, if32.bus_we, if32.bus_byteen}, 6'b100000);
        if32.bus_gnt = 1'b1;
        @(negedge clk);
        if32.bus_gnt = 1'b0;
        chk("lb_wait", if32.rsp_valid, 1'b0);
        if32.bus_rvalid = 1'b1; if32.bus_rdata = 32'h1234_80FF;
        @(negedge clk);
        if32.bus_rvalid = 1'b1; if32.bus_rdata = 32'h0;
        chk("lb_rsp", {if32.rsp_valid, if32.rsp_exc}, 3'b100);
        chk("lb_rdata", if32.rsp_rdata, 32'hFFFF_FF80);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lb_hold", {if32.rsp_valid, if32.rsp_exc, if32.rsp_rdata}, {3'b100, 32'hFFFF_FF80});
        end
        if32.bus_rvalid = 1'b0;
        rsp32("lb");

        load32(4'b0001, 32'h2001, 32'h1234_80FF);
        chk("lbu_rdata", if32.rsp_rdata, 32'h0000_0080);
        rsp32("lbu");

        load32(4'b0010, 32'h2002, 32'h8001_1234);
        chk("lh_hi", if32.rsp_rdata, 32'hFFFF_8001);
        rsp32("lh");

        // Faults: no bus traffic, response in cycle 1
        req32(4'b0010, 32'h2003, 32'h0);
        chk("mis_rsp", {if32.rsp_valid, if32.rsp_exc, if32.bus_req}, 4'b1010);
        chk("mis_rdata", if32.rsp_rdata, 0);
        rsp32("mis");

        req32(4'b0110, 32'h2001, 32'h0);
        chk("ill_rsp", {if32.rsp_valid, if32.rsp_exc, if32.bus_req}, 4'b1100);
        rsp32("ill");

        // 64-bit: LWU lane 4, SD, SH lane 6
        load64(4'b0101, 32'h4004, 64'h8765_4321_0000_0000);
        chk("lwu64", if64.rsp_rdata, 64'h0000_0000_8765_4321);
        chk("lwu64_exc", {if64.rsp_valid, if64.rsp_exc}, 3'b100);
        rsp64("lwu64");

        req64(4'b1110, 32'h4008, 64'h1122_3344_5566_7788);
        chk("sd_be", if64.bus_byteen, 8'hFF);
        chk("sd_wdata", if64.bus_wdata, 64'h1122_3344_5566_7788);
        chk("sd_addr", if64.bus_addr, 32'h0000_4008);
        if64.bus_gnt = 1'b1;
        @(negedge clk);
        if64.bus_gnt = 1'b0;
        chk("sd_rsp", {if64.rsp_valid, if64.rsp_exc}, 3'b100);
        rsp64("sd");

        req64(4'b1010, 32'h4006, 64'hFFFF_FFFF_FFFF_BEEF);
        chk("sh_be", if64.bus_byteen, 8'hC0);
        chk("sh_wdata", if64.bus_wdata, 64'hBEEF_0000_0000_0000);
        chk("sh_addr", if64.bus_addr, 32'h0000_4000);
        if64.bus_gnt = 1'b1;
        @(negedge clk);
        if64.bus_gnt = 1'b0;
        rsp64("sh");

        // Timeout: grant at edge 1, response after edge 6
        req64(4'b0100, 32'h5000, 64'h0);
        if64.bus_gnt = 1'b1;
        @(negedge clk);
        if64.bus_gnt = 1'b0;
        repeat (4) @(negedge clk);
        chk("to_early", if64.rsp_valid, 1'b0);
        @(negedge clk);
        chk("to_rsp", {if64.rsp_valid, if64.rsp_exc}, 3'b111);
        chk("to_rdata", if64.rsp_rdata, 0);
        if64.bus_rvalid = 1'b1; if64.bus_rdata = '1;
        @(negedge clk);
        if64.bus_rvalid = 1'b0; if64.bus_rdata = '0;
        chk("to_late", {if64.rsp_valid, if64.rsp_exc, if64.rsp_rdata}, {3'b111, 64'h0});
        rsp64("to");

        load64(4'b0000, 32'h5003, 64'h0000_0000_AB00_0000);
        chk("lb64_after_to", if64.rsp_rdata, 64'hFFFF_FFFF_FFFF_FFAB);
        rsp64("lb64");

        // Reset in WAIT_R aborts with no response
        req32(4'b0100, 32'h3000, 32'h0);
        chk("ab_issue", if32.bus_req, 1'b1);
        if32.bus_gnt = 1'b1;
        @(negedge clk);
        if32.bus_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("ab_bus", {if32.bus_req, if32.bus_we, if32.bus_byteen, if32.bus_addr, if32.bus_wdata}, 0);
        chk("ab_ready", {if32.req_ready, if32.rsp_valid}, 2'b10);
        @(negedge clk);
        rst_n = 1'b1;
        if32.bus_rvalid = 1'b1; if32.bus_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        if32.bus_rvalid = 1'b0;
        @(negedge clk);
        chk("ab_norsp", {if32.req_ready, if32.rsp_valid, if32.rsp_rdata}, {2'b10, 32'h0});

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
